// File: rtl/combo_lock_pkg.sv
// Shared state encodings and 7-segment patterns for the parametrised combination lock.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAccess  = 3'd1,
        StSetNew  = 3'd2,
        StLockout = 3'd3,
        StConfirm = 3'd4
    } state_e;

    // Segment order is a..g, left to right.
    localparam logic [1:7] SegIdle    = 7'b1111110;
    localparam logic [1:7] SegAccess  = 7'b1100010;
    localparam logic [1:7] SegSetNew  = 7'b1101010;
    localparam logic [1:7] SegLockout = 7'b0001000;
    localparam logic [1:7] SegConfirm = 7'b0110000;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle registered pulse the cycle after a button is first seen high.
module edge_pulse (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_pulse
);

    logic r_hist;
    logic r_pulse;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_hist  <= i_raw;
            r_pulse <= i_raw & ~r_hist;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/combo_lock_param.sv
// Parametrised combination lock with timed lockout and optional access timeout.
// Define COMBO_CONFIRM_EN to require re-entry of a new code before it is committed.
module combo_lock_param
    import combo_lock_pkg::*;
#(
    parameter int unsigned       CODE_W         = 4,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = CODE_W'(4'b0110),
    parameter int unsigned       MAX_ATTEMPTS   = 2,
    parameter int unsigned       LOCKOUT_CYCLES = 50000000,
    parameter int unsigned       ACCESS_TIMEOUT = 0
) (
    input  logic                                CLOCK_50,
    input  logic                                Reset,
    input  logic                                Validate,
    input  logic                                Modify,
    input  logic [CODE_W-1:0]                   code_in,
    output logic                                unlocked,
    output logic                                alert,
    output logic [2:0]                          state_o,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_o,
    output logic                                validatepulse,
    output logic                                modifypulse,
    output logic [1:7]                          output_display
);

    localparam int unsigned AW   = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned TMAX = (LOCKOUT_CYCLES > ACCESS_TIMEOUT) ? LOCKOUT_CYCLES
                                                                     : ACCESS_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] LockLoad   = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] AccessLoad = TW'(ACCESS_TIMEOUT);
    localparam logic [AW-1:0] AttemptMax = AW'(MAX_ATTEMPTS);

    state_e            r_state, w_state_d;
    logic [CODE_W-1:0] r_code, w_code_d;
    logic [AW-1:0]     r_attempts, w_attempts_d, w_attempts_inc;
    logic [TW-1:0]     r_timer, w_timer_d, w_timer_dec;
    logic              w_vpulse, w_mpulse, w_match, w_wrong;
`ifdef COMBO_CONFIRM_EN
    logic [CODE_W-1:0] r_pending, w_pending_d;
`endif

    edge_pulse u_validate_pulse (
        .i_clk   (CLOCK_50),
        .i_rst   (Reset),
        .i_raw   (Validate),
        .o_pulse (w_vpulse)
    );

    edge_pulse u_modify_pulse (
        .i_clk   (CLOCK_50),
        .i_rst   (Reset),
        .i_raw   (Modify),
        .o_pulse (w_mpulse)
    );

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_state    <= StIdle;
            r_code     <= DEFAULT_CODE;
            r_attempts <= '0;
            r_timer    <= '0;
`ifdef COMBO_CONFIRM_EN
            r_pending  <= '0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_code     <= w_code_d;
            r_attempts <= w_attempts_d;
            r_timer    <= w_timer_d;
`ifdef COMBO_CONFIRM_EN
            r_pending  <= w_pending_d;
`endif
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_code_d       = r_code;
        w_attempts_d   = r_attempts;
        w_timer_d      = r_timer;
`ifdef COMBO_CONFIRM_EN
        w_pending_d    = r_pending;
`endif
        w_wrong        = 1'b0;
        w_match        = (code_in == r_code);
        w_attempts_inc = r_attempts + 1'b1;
        w_timer_dec    = (r_timer != '0) ? r_timer - 1'b1 : '0;

        case (r_state)
            StIdle: begin
                // Validate wins over a simultaneous modify press.
                if (w_vpulse) begin
                    if (w_match) begin
                        w_state_d    = StAccess;
                        w_attempts_d = '0;
                        w_timer_d    = AccessLoad;
                    end else begin
                        w_wrong = 1'b1;
                    end
                end else if (w_mpulse) begin
                    if (w_match) begin
                        w_state_d    = StSetNew;
                        w_attempts_d = '0;
                    end else begin
                        w_wrong = 1'b1;
                    end
                end
            end
            StAccess: begin
                if (w_vpulse) begin
                    w_state_d = StIdle;
                end else if (ACCESS_TIMEOUT != 0) begin
                    w_timer_d = w_timer_dec;
                    if (r_timer <= TW'(1)) begin
                        w_state_d = StIdle;
                    end
                end
            end
            StSetNew: begin
                if (w_vpulse || w_mpulse) begin
`ifdef COMBO_CONFIRM_EN
                    w_pending_d = code_in;
                    w_state_d   = StConfirm;
`else
                    w_code_d    = code_in;
                    w_state_d   = StIdle;
`endif
                end
            end
`ifdef COMBO_CONFIRM_EN
            StConfirm: begin
                if (w_vpulse || w_mpulse) begin
                    if (code_in == r_pending) begin
                        w_code_d = r_pending;
                    end
                    w_state_d = StIdle;
                end
            end
`endif
            StLockout: begin
                w_timer_d = w_timer_dec;
                if (r_timer <= TW'(1)) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_wrong) begin
            if (w_attempts_inc == AttemptMax) begin
                w_state_d    = StLockout;
                w_attempts_d = '0;
                w_timer_d    = LockLoad;
            end else begin
                w_attempts_d = w_attempts_inc;
            end
        end
    end

    always_comb begin
        output_display = SegIdle;
        case (r_state)
            StIdle:    output_display = SegIdle;
            StAccess:  output_display = SegAccess;
            StSetNew:  output_display = SegSetNew;
            StLockout: output_display = SegLockout;
`ifdef COMBO_CONFIRM_EN
            StConfirm: output_display = SegConfirm;
`endif
            default:   output_display = SegIdle;
        endcase
    end

    assign unlocked      = (r_state == StAccess);
    assign alert         = (r_state == StLockout);
    assign state_o       = r_state;
    assign attempts_o    = r_attempts;
    assign validatepulse = w_vpulse;
    assign modifypulse   = w_mpulse;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed bench for combo_lock_param; honours COMBO_CONFIRM_EN when defined.
module tb_combo_lock_param;

    logic       clk;
    logic       rst;
    logic       vbtn;
    logic       mbtn;
    logic [3:0] code;
    logic       unlocked;
    logic       alert;
    logic [2:0] state;
    logic [1:0] attempts;
    logic       vpulse;
    logic       mpulse;
    logic [1:7] disp;

    int checks   = 0;
    int failures = 0;

    combo_lock_param #(
        .CODE_W         (4),
        .DEFAULT_CODE   (4'd6),
        .MAX_ATTEMPTS   (2),
        .LOCKOUT_CYCLES (8),
        .ACCESS_TIMEOUT (16)
    ) dut (
        .CLOCK_50       (clk),
        .Reset          (rst),
        .Validate       (vbtn),
        .Modify         (mbtn),
        .code_in        (code),
        .unlocked       (unlocked),
        .alert          (alert),
        .state_o        (state),
        .attempts_o     (attempts),
        .validatepulse  (vpulse),
        .modifypulse    (mpulse),
        .output_display (disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Press for one cycle; returns once the FSM has consumed the pulse.
    task automatic press_v(input logic [3:0] c);
        code = c;
        vbtn = 1'b1;
        tick(1);
        vbtn = 1'b0;
        tick(1);
    endtask

    task automatic press_m(input logic [3:0] c);
        code = c;
        mbtn = 1'b1;
        tick(1);
        mbtn = 1'b0;
        tick(1);
    endtask

    initial begin
        int pulses;
        int entries;
        logic [2:0] prev;

        rst  = 1'b1;
        vbtn = 1'b0;
        mbtn = 1'b0;
        code = 4'd0;
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_alert", alert, 0);
        chk("rst_attempts", attempts, 0);
        chk("rst_disp", disp, 7'b1111110);
        chk("rst_vpulse", vpulse, 0);
        rst = 1'b0;
        tick(1);

        // Correct code unlocks two edges after the raw rise, then times out after 16 cycles.
        code = 4'd6;
        vbtn = 1'b1;
        tick(1);
        chk("pulse_first", vpulse, 1);
        chk("pulse_state_idle", state, 0);
        vbtn = 1'b0;
        tick(1);
        chk("pulse_one_cycle", vpulse, 0);
        chk("unlock", unlocked, 1);
        chk("access_disp", disp, 7'b1100010);
        tick(15);
        chk("access_last_cycle", unlocked, 1);
        tick(1);
        chk("access_timeout", state, 0);
        chk("idle_disp", disp, 7'b1111110);

        // Two wrong codes trigger an 8-cycle lockout that ignores presses.
        press_v(4'd3);
        chk("wrong1_attempts", attempts, 1);
        chk("wrong1_state", state, 0);
        press_v(4'd5);
        chk("lock_attempts", attempts, 0);
        chk("lock_alert", alert, 1);
        chk("lock_disp", disp, 7'b0001000);
        press_v(4'd6);
        chk("lock_ignores", state, 3);
        tick(5);
        chk("lock_last_cycle", alert, 1);
        tick(1);
        chk("lock_exit", state, 0);
        chk("lock_exit_alert", alert, 0);

        // Change code to 9.
        press_m(4'd6);
        chk("setnew_state", state, 2);
        chk("setnew_disp", disp, 7'b1101010);
        press_v(4'd9);
`ifdef COMBO_CONFIRM_EN
        chk("confirm_state", state, 4);
        chk("confirm_disp", disp, 7'b0110000);
        press_v(4'd9);
`endif
        chk("setnew_done", state, 0);
        press_v(4'd6);
        chk("oldcode_rejected", attempts, 1);
        press_v(4'd9);
        chk("newcode_unlocks", state, 1);
        chk("newcode_attempts", attempts, 0);
        press_v(4'd9);
        chk("access_validate_exit", state, 0);

        // Holding Validate gives a single pulse and a single ACCESS entry.
        pulses  = 0;
        entries = 0;
        prev    = state;
        code    = 4'd9;
        vbtn    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (vpulse) pulses++;
            if (state == 3'd1 && prev != 3'd1) entries++;
            prev = state;
        end
        chk("hold_pulses", pulses, 1);
        chk("hold_entries", entries, 1);
        chk("hold_timed_out", state, 0);
        vbtn = 1'b0;
        tick(1);
        press_v(4'd9);
        chk("repress_unlock", state, 1);
        press_v(4'd9);
        chk("repress_exit", state, 0);

        // Asynchronous reset in the third lockout cycle.
        press_v(4'd1);
        press_v(4'd2);
        chk("lock2_state", state, 3);
        tick(2);
        rst = 1'b1;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_alert", alert, 0);
        chk("async_rst_attempts", attempts, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

`ifdef COMBO_CONFIRM_EN
        // Mismatched confirmation leaves the code unchanged.
        press_m(4'd6);
        press_v(4'd9);
        chk("cfm_state", state, 4);
        press_v(4'd10);
        chk("cfm_mismatch_idle", state, 0);
        press_v(4'd9);
        chk("cfm_not_committed", attempts, 1);
        press_v(4'd6);
        chk("cfm_code_kept", state, 1);
        press_v(4'd6);
        chk("cfm_exit", state, 0);
`endif

        // Simultaneous presses with the reset code: validate wins.
        code = 4'd6;
        vbtn = 1'b1;
        mbtn = 1'b1;
        tick(1);
        chk("both_vpulse", vpulse, 1);
        chk("both_mpulse", mpulse, 1);
        vbtn = 1'b0;
        mbtn = 1'b0;
        tick(1);
        chk("both_access", state, 1);
        press_v(4'd6);
        chk("both_exit", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
